// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: address width, FSM encoding, queue entry.
// Imported by the fetch unit and its queue.
package if_fetch_unit_pkg;

  localparam int ADDRESS_LEN = 32;

  typedef logic [ADDRESS_LEN-1:0] addr_t;

  localparam addr_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_DISCARD = 2'b10
  } fetch_state_t;

  typedef struct packed {
    addr_t pc;
    addr_t instr;
  } fetch_entry_t;

  function automatic addr_t align_word(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular queue of fetched {pc+4, instruction} entries.
// Flush wins over push and pop in the same cycle.
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr] <= i_push_data;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one-outstanding memory handshake, redirect, and
// a small prefetch queue feeding the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int    QUEUE_DEPTH = 2,
  parameter addr_t RESET_PC    = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  freeze,
  input  logic  branch_taken,
  input  addr_t branch_addr,
  output logic  mem_req,
  output addr_t mem_addr,
  input  logic  mem_ack,
  input  addr_t mem_rdata,
  output addr_t pc,
  output addr_t instruction,
  output logic  valid
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t r_state;
  addr_t        r_fetch_pc;
  logic         r_mem_req;
  addr_t        r_mem_addr;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  addr_t         w_target;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_room;

  assign w_target = align_word(branch_addr);
  assign w_valid  = (w_count != '0);
  assign w_pop    = w_valid && !freeze;
  assign w_room   = (w_count < CW'(QUEUE_DEPTH));

  // Only a live WAIT ack delivers data; a redirect in the same cycle kills it.
  assign w_push = (r_state == ST_WAIT) && mem_ack && !branch_taken;

  assign w_push_data.pc    = r_mem_addr + PC_STEP;
  assign w_push_data.instr = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (branch_taken) begin
            r_fetch_pc <= w_target;
          end else if (w_room) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
            r_fetch_pc <= branch_taken ? w_target
                                       : r_fetch_pc + PC_STEP;
          end else if (branch_taken) begin
            r_fetch_pc <= w_target;
            r_state    <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (branch_taken) r_fetch_pc <= w_target;
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (branch_taken),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign valid       = w_valid;
  assign instruction = w_valid ? w_head.instr : '0;
  assign pc          = w_valid ? w_head.pc : r_fetch_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: address-tagged memory model,
// scoreboard of expected {pc, instruction} retired downstream.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  freeze = 1'b1;
  logic  branch_taken = 1'b0;
  addr_t branch_addr = '0;
  logic  mem_req;
  addr_t mem_addr;
  logic  mem_ack = 1'b0;
  addr_t mem_rdata = 32'hDEAD_BEEF;
  addr_t pc;
  addr_t instruction;
  logic  valid;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 0;
  bit hold = 1'b1;

  fetch_entry_t sb[$];
  fetch_entry_t mon_e;

  if_fetch_unit #(
    .QUEUE_DEPTH (2),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: acks once the request has waited 'lat' cycles, data = address.
  int    wcnt = 0;
  addr_t cap = '0;
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      wcnt      = 0;
    end else begin
      if (wcnt == 0) cap = mem_addr;
      else chk("mem_addr_hold", mem_addr, cap);
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
      wcnt++;
    end
  end

  // Downstream consumer: retires the head only while expectations remain.
  always @(negedge clk) begin
    freeze = hold || (sb.size() == 0);
    if (!freeze && valid && !branch_taken && rst) begin
      mon_e = sb.pop_front();
      chk("head_pc", pc, mon_e.pc);
      chk("head_instr", instruction, mon_e.instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input addr_t start, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.instr = start + 32'(4 * i);
      e.pc    = start + 32'(4 * (i + 1));
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    hold = 1'b0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    hold = 1'b1;
  endtask

  task automatic wait_req(input addr_t a, input int budget);
    int k;
    k = 0;
    while (!(mem_req && mem_addr == a) && k < budget) begin
      tick();
      k++;
    end
    chk("req_seen", mem_req, 1);
    chk("req_addr", mem_addr, a);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    hold = 1'b1;
    branch_taken = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int k;
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", pc, 0);

    // Zero-wait stream, consumer always ready.
    lat = 0;
    rst = 1'b1;
    expect_run(32'h0, 3);
    hold = 1'b0;
    tick();
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 0);
    drain(40);

    // Three wait cycles on every request.
    do_reset();
    lat = 3;
    rst = 1'b1;
    wait_req(32'h4, 20);
    repeat (3) begin
      tick();
      chk("lat_req", mem_req, 1);
      chk("lat_addr", mem_addr, 32'h4);
    end
    tick();
    chk("lat_done", mem_req, 0);
    expect_run(32'h0, 2);
    drain(40);

    // Long freeze fills the queue and stops requests.
    do_reset();
    lat = 0;
    rst = 1'b1;
    repeat (4) tick();
    repeat (6) begin
      tick();
      chk("frz_no_req", mem_req, 0);
    end
    chk("frz_valid", valid, 1);
    chk("frz_pc", pc, 32'h4);
    expect_run(32'h0, 3);
    drain(40);

    // Redirect while the 0x8 request is waiting.
    do_reset();
    lat = 0;
    rst = 1'b1;
    repeat (6) tick();
    lat = 20;
    expect_run(32'h0, 2);
    drain(20);
    wait_req(32'h8, 5);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    expect_run(32'h100, 2);
    tick();
    branch_taken = 1'b0;
    lat = 0;
    chk("br_valid", valid, 0);
    chk("br_pc", pc, 32'h100);
    chk("br_instr", instruction, 0);
    chk("br_req_held", mem_req, 1);
    chk("br_addr_held", mem_addr, 32'h8);
    tick();
    chk("disc_valid", valid, 0);
    chk("disc_pc", pc, 32'h100);
    drain(40);

    // Redirect in the same cycle as an ack, unaligned target.
    do_reset();
    lat = 2;
    rst = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!mem_ack && k < 20);
    chk("ack_seen", mem_ack, 1);
    branch_taken = 1'b1;
    branch_addr  = 32'h102;
    tick();
    branch_taken = 1'b0;
    chk("bra_valid", valid, 0);
    chk("bra_req", mem_req, 0);
    chk("bra_pc", pc, 32'h100);
    tick();
    chk("bra_next_req", mem_req, 1);
    chk("bra_next_addr", mem_addr, 32'h100);
    expect_run(32'h100, 2);
    drain(40);

    // Asynchronous reset in the middle of a handshake.
    do_reset();
    lat = 0;
    rst = 1'b1;
    wait_req(32'h4, 10);
    lat = 10;
    #2;
    chk("pre_rst_valid", valid, 1);
    chk("pre_rst_pc", pc, 32'h4);
    rst = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_valid", valid, 0);
    chk("arst_pc", pc, 0);
    sb.delete();
    repeat (2) tick();
    lat = 0;
    rst = 1'b1;
    expect_run(32'h0, 3);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
